// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle for sync_fifo_ctrl; the master drives requests, the FIFO (slave) drives status.
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic                  clr_flags;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en, clr_flags,
    input  dout, dout_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_flags,
    output dout, dout_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock parametrised FIFO with standard or show-ahead read, level/threshold flags
// and sticky overflow/underflow error flags.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic            clk,
  input  logic            reset,
  sync_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  rd_acc, wr_acc;
  logic                  full_i, empty_i;

  assign empty_i = (count == '0);
  assign full_i  = (count == DEPTH_C);

  // A push into a full FIFO is allowed only when the same cycle frees a slot.
  assign rd_acc = bus.rd_en & ~empty_i;
  assign wr_acc = bus.wr_en & (~full_i | rd_acc);

  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);
  assign bus.level        = count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      // A fresh error in the clearing cycle keeps its flag set.
      bus.overflow  <= (bus.overflow  & ~bus.clr_flags) | (bus.wr_en & ~wr_acc);
      bus.underflow <= (bus.underflow & ~bus.clr_flags) | (bus.rd_en & empty_i);
    end
  end

  // NOTE: the storage array has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[wr_ptr] <= bus.din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // NOTE: the ternary gives dout a value on every path, so no latch is inferred.
      assign bus.dout       = empty_i ? '0 : mem[rd_ptr];
      assign bus.dout_valid = ~empty_i;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (reset) begin
          bus.dout       <= '0;
          bus.dout_valid <= 1'b0;
        end else begin
          if (rd_acc) bus.dout <= mem[rd_ptr];
          bus.dout_valid <= rd_acc;
        end
      end
    end
  endgenerate
endmodule
